predictor_update_queue: RTL

//  Sequences all writes into the 2-bit local branch predictor table. After reset, or on

---
 rtl/predictor_update_queue_if.sv | 35 +++
 rtl/predictor_update_queue.sv | 138 +++++++++++++
 2 files changed

// File: rtl/predictor_update_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : predictor_update_queue_if
//  Purpose  : Commit-side enqueue and predictor-side write signals of the
//             predictor update queue.
//  Revision : 1.0  initial release
// ============================================================================
interface predictor_update_queue_if #(
    parameter int LOCAL_WIDTH = 12
);
    logic                   readyIn;
    logic                   enqValid;
    logic [31:0]            enqInstr;
    logic                   enqTaken;
    logic                   initStart;
    logic                   full;
    logic                   busy;
    logic                   initValid;
    logic [LOCAL_WIDTH-1:0] initIdx;
    logic                   updateValid;
    logic [31:0]            updateInstr;
    logic                   taken;
    logic [7:0]             dropCount;

    modport master (
        output readyIn, enqValid, enqInstr, enqTaken, initStart,
        input  full, busy, initValid, initIdx, updateValid, updateInstr, taken, dropCount
    );

    modport slave (
        input  readyIn, enqValid, enqInstr, enqTaken, initStart,
        output full, busy, initValid, initIdx, updateValid, updateInstr, taken, dropCount
    );
endinterface
`default_nettype wire

// File: rtl/predictor_update_queue.sv
`default_nettype none
// ============================================================================
//  Module   : predictor_update_queue
//  Purpose  : Sweeps the local 2-bit predictor table to weakly-not-taken and
//             drains committed branch outcomes into its single update port.
//  Revision : 1.0  initial release
// ============================================================================
module predictor_update_queue #(
    parameter int LOCAL_WIDTH = 12,
    parameter int DEPTH_WIDTH = 2,
    parameter int DEPTH       = 2 ** DEPTH_WIDTH
) (
    input  wire logic               clockIn,
    input  wire logic               resetIn,
    predictor_update_queue_if.slave bus
);
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [LOCAL_WIDTH-1:0] c_LAST_IDX    = {LOCAL_WIDTH{1'b1}};
    localparam logic [DEPTH_WIDTH:0]   c_DEPTH_COUNT = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   c_COUNT_ONE   = (DEPTH_WIDTH+1)'(1);

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [LOCAL_WIDTH-1:0] r_initIdx;
    logic [LOCAL_WIDTH-1:0] w_initIdxNext;

    logic [31:0]            r_memInstr [DEPTH];
    logic                   r_memTaken [DEPTH];
    logic [DEPTH_WIDTH-1:0] r_head;
    logic [DEPTH_WIDTH-1:0] r_tail;
    logic [DEPTH_WIDTH:0]   r_count;

    logic                   r_updateValid;
    logic [31:0]            r_updateInstr;
    logic                   r_taken;
    logic [7:0]             r_dropCount;

    logic                   w_full;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;

    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            r_state   <= ST_INIT;
            r_initIdx <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_initIdx <= w_initIdxNext;
        end
    end

    // Popping is suppressed on the initStart edge so a fresh update never
    // overlaps the first sweep write.
    always_comb begin
        w_stateNext   = r_state;
        w_initIdxNext = r_initIdx;
        w_pop         = 1'b0;
        w_full        = (r_count == c_DEPTH_COUNT);
        w_push        = bus.enqValid & bus.readyIn & ~w_full;
        w_drop        = bus.enqValid & bus.readyIn & w_full;
        if (bus.readyIn) begin
            case (r_state)
                ST_INIT: begin
                    if (r_initIdx == c_LAST_IDX) begin
                        w_stateNext   = ST_RUN;
                        w_initIdxNext = '0;
                    end else begin
                        w_initIdxNext = r_initIdx + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.initStart) begin
                        w_stateNext   = ST_INIT;
                        w_initIdxNext = '0;
                    end else begin
                        w_pop = (r_count != '0);
                    end
                end
                default: begin
                    w_stateNext   = ST_INIT;
                    w_initIdxNext = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn && w_push) begin
            r_memInstr[r_tail] <= bus.enqInstr;
            r_memTaken[r_tail] <= bus.enqTaken;
        end
    end

    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_updateValid <= 1'b0;
            r_updateInstr <= '0;
            r_taken       <= 1'b0;
            r_dropCount   <= '0;
        end else if (bus.readyIn) begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head        <= r_head + 1'b1;
                r_updateInstr <= r_memInstr[r_head];
                r_taken       <= r_memTaken[r_head];
            end
            r_updateValid <= w_pop;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_COUNT_ONE;
                2'b01:   r_count <= r_count - c_COUNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_dropCount != 8'hFF)) begin
                r_dropCount <= r_dropCount + 8'd1;
            end
        end
    end

    assign bus.full        = w_full;
    assign bus.busy        = (r_state == ST_INIT);
    assign bus.initValid   = (r_state == ST_INIT);
    assign bus.initIdx     = r_initIdx;
    assign bus.updateValid = r_updateValid;
    assign bus.updateInstr = r_updateInstr;
    assign bus.taken       = r_taken;
    assign bus.dropCount   = r_dropCount;
endmodule
`default_nettype wire
